// File: rtl/lsu_axi_ctrl.sv
// LSU memory-side controller: turns one execute-stage load/store into a single
// AXI4-Lite transaction, returning extended load data or a trap.
module lsu_axi_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            lsu_op_i,
   input  logic [2:0]            lsu_width_i,
   input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
   input  logic [31:0]           lsu_wdata_i,
   output logic                  lsu_bp_o,
   output logic [31:0]           ld_data_o,
   output logic                  ld_valid_o,
   output logic                  trap_o,
   output logic [3:0]            trap_cause_o,
   output logic [ADDR_WIDTH-1:0] trap_addr_o,
   output logic [ADDR_WIDTH-1:0] m_awaddr,
   output logic [2:0]            m_awprot,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [31:0]           m_wdata,
   output logic [3:0]            m_wstrb,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic [2:0]            m_arprot,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [31:0]           m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rvalid,
   output logic                  m_rready
);

   localparam logic [1:0] OP_LOAD      = 2'd1;
   localparam logic [1:0] OP_STORE     = 2'd2;
   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
   localparam logic [3:0] CAUSE_LD_ERR = 4'd5;
   localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
   localparam logic [3:0] CAUSE_ST_ERR = 4'd7;

   typedef enum logic [2:0] {IDLE, ST_REQ, ST_RSP, LD_REQ, LD_RSP} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d, addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] trap_addr_q, trap_addr_d;
   logic [31:0]           wdata_q, wdata_d, ld_data_q, ld_data_d;
   logic [3:0]            wstrb_q, wstrb_d, trap_cause_q, trap_cause_d;
   logic [2:0]            width_q, width_d;
   logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                  arvalid_q, arvalid_d, rready_q, rready_d;
   logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                  ld_valid_q, ld_valid_d, trap_q, trap_d;

   logic                  op_ld, op_st, is_byte, is_half, misaligned;
   logic                  aw_done_n, w_done_n;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [31:0]           st_data, ld_ext;
   logic [3:0]            st_strb;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;

   assign op_ld      = (lsu_op_i == OP_LOAD);
   assign op_st      = (lsu_op_i == OP_STORE);
   assign is_byte    = (lsu_width_i[1:0] == 2'b00);
   assign is_half    = (lsu_width_i[1:0] == 2'b01);
   assign misaligned = (is_half && lsu_addr_i[0]) ||
                       (!is_byte && !is_half && (lsu_addr_i[1:0] != 2'b00));
   assign word_addr  = {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
   assign aw_done_n  = aw_done_q | (awvalid_q & m_awready);
   assign w_done_n   = w_done_q  | (wvalid_q  & m_wready);

   // Store lane replication and byte strobes
   always_comb begin
      st_data = lsu_wdata_i;
      st_strb = 4'b1111;
      if (is_byte) begin
         st_data = {4{lsu_wdata_i[7:0]}};
         st_strb = 4'b0001 << lsu_addr_i[1:0];
      end else if (is_half) begin
         st_data = {2{lsu_wdata_i[15:0]}};
         st_strb = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
      end
   end

   // Load lane extraction and extension
   always_comb begin
      ld_byte = m_rdata[{addr_q[1:0], 3'b000} +: 8];
      ld_half = addr_q[1] ? m_rdata[31:16] : m_rdata[15:0];
      unique case (width_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = m_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         awaddr_q     <= '0;
         araddr_q     <= '0;
         addr_q       <= '0;
         trap_addr_q  <= '0;
         wdata_q      <= '0;
         ld_data_q    <= '0;
         wstrb_q      <= '0;
         trap_cause_q <= '0;
         width_q      <= '0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         ld_valid_q   <= 1'b0;
         trap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         awaddr_q     <= awaddr_d;
         araddr_q     <= araddr_d;
         addr_q       <= addr_d;
         trap_addr_q  <= trap_addr_d;
         wdata_q      <= wdata_d;
         ld_data_q    <= ld_data_d;
         wstrb_q      <= wstrb_d;
         trap_cause_q <= trap_cause_d;
         width_q      <= width_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         ld_valid_q   <= ld_valid_d;
         trap_q       <= trap_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      awaddr_d     = awaddr_q;
      araddr_d     = araddr_q;
      addr_d       = addr_q;
      trap_addr_d  = trap_addr_q;
      wdata_d      = wdata_q;
      ld_data_d    = ld_data_q;
      wstrb_d      = wstrb_q;
      trap_cause_d = trap_cause_q;
      width_d      = width_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      ld_valid_d   = 1'b0;
      trap_d       = 1'b0;
      lsu_bp_o     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (op_ld || op_st) begin
               if (misaligned) begin
                  trap_d       = 1'b1;
                  trap_cause_d = op_ld ? CAUSE_LD_MIS : CAUSE_ST_MIS;
                  trap_addr_d  = lsu_addr_i;
               end else begin
                  lsu_bp_o = 1'b1;
                  addr_d   = lsu_addr_i;
                  width_d  = lsu_width_i;
                  if (op_st) begin
                     awaddr_d  = word_addr;
                     wdata_d   = st_data;
                     wstrb_d   = st_strb;
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                     state_d   = ST_REQ;
                  end else begin
                     araddr_d  = word_addr;
                     arvalid_d = 1'b1;
                     state_d   = LD_REQ;
                  end
               end
            end
         end
         // AW and W retire independently; B is accepted only once both are done
         ST_REQ: begin
            lsu_bp_o  = 1'b1;
            awvalid_d = awvalid_q & ~m_awready;
            wvalid_d  = wvalid_q & ~m_wready;
            aw_done_d = aw_done_n;
            w_done_d  = w_done_n;
            if (aw_done_n && w_done_n) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               bready_d  = 1'b1;
               state_d   = ST_RSP;
            end
         end
         ST_RSP: begin
            lsu_bp_o = !(m_bvalid && bready_q);
            if (m_bvalid && bready_q) begin
               bready_d = 1'b0;
               state_d  = IDLE;
               if (m_bresp != RESP_OKAY) begin
                  trap_d       = 1'b1;
                  trap_cause_d = CAUSE_ST_ERR;
                  trap_addr_d  = addr_q;
               end
            end
         end
         LD_REQ: begin
            lsu_bp_o = 1'b1;
            if (m_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = LD_RSP;
            end
         end
         LD_RSP: begin
            lsu_bp_o = !(m_rvalid && rready_q);
            if (m_rvalid && rready_q) begin
               rready_d = 1'b0;
               state_d  = IDLE;
               if (m_rresp == RESP_OKAY) begin
                  ld_valid_d = 1'b1;
                  ld_data_d  = ld_ext;
               end else begin
                  trap_d       = 1'b1;
                  trap_cause_d = CAUSE_LD_ERR;
                  trap_addr_d  = addr_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ld_data_o    = ld_data_q;
   assign ld_valid_o   = ld_valid_q;
   assign trap_o       = trap_q;
   assign trap_cause_o = trap_cause_q;
   assign trap_addr_o  = trap_addr_q;
   assign m_awaddr     = awaddr_q;
   assign m_awprot     = 3'b000;
   assign m_awvalid    = awvalid_q;
   assign m_wdata      = wdata_q;
   assign m_wstrb      = wstrb_q;
   assign m_wvalid     = wvalid_q;
   assign m_bready     = bready_q;
   assign m_araddr     = araddr_q;
   assign m_arprot     = 3'b000;
   assign m_arvalid    = arvalid_q;
   assign m_rready     = rready_q;

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Directed bench for lsu_axi_ctrl: a scripted AXI4-Lite slave with per-test
// handshake delays, checking bus fields, backpressure, load results and traps.
module tb_lsu_axi_ctrl;

   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    lsu_op_i;
   logic [2:0]    lsu_width_i;
   logic [AW-1:0] lsu_addr_i;
   logic [31:0]   lsu_wdata_i;
   logic          lsu_bp_o;
   logic [31:0]   ld_data_o;
   logic          ld_valid_o;
   logic          trap_o;
   logic [3:0]    trap_cause_o;
   logic [AW-1:0] trap_addr_o;
   logic [AW-1:0] m_awaddr, m_araddr;
   logic [2:0]    m_awprot, m_arprot;
   logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic          m_arvalid, m_arready, m_rvalid, m_rready;
   logic [31:0]   m_wdata, m_rdata;
   logic [3:0]    m_wstrb;
   logic [1:0]    m_bresp, m_rresp;

   int n_checks = 0;
   int n_fail   = 0;

   lsu_axi_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .lsu_op_i(lsu_op_i), .lsu_width_i(lsu_width_i), .lsu_addr_i(lsu_addr_i),
      .lsu_wdata_i(lsu_wdata_i), .lsu_bp_o(lsu_bp_o),
      .ld_data_o(ld_data_o), .ld_valid_o(ld_valid_o),
      .trap_o(trap_o), .trap_cause_o(trap_cause_o), .trap_addr_o(trap_addr_o),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      lsu_op_i  = 2'd0;
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bvalid  = 1'b0;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
   endtask

   task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] w, input int aw_dly, input int w_dly,
                            input int b_dly, input logic [1:0] resp,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
      int aw_hs, w_hs, k, bk;
      bit done, bp_ok;
      aw_hs = 0; w_hs = 0; k = 0; bk = 0; done = 1'b0; bp_ok = 1'b1;
      @(negedge clk);
      lsu_op_i = 2'd2; lsu_width_i = w; lsu_addr_i = a; lsu_wdata_i = d;
      #1 check_eq({tag, " bp_accept"}, 32'(lsu_bp_o), 32'd1);
      while (!done && k < 60) begin
         @(negedge clk);
         m_awready = (k >= aw_dly);
         m_wready  = (k >= w_dly);
         m_bvalid  = m_bready && (bk >= b_dly);
         m_bresp   = resp;
         #1;
         if (m_awvalid && m_awready) begin
            aw_hs++;
            check_eq({tag, " awaddr"}, m_awaddr, {a[31:2], 2'b00});
         end
         if (m_wvalid && m_wready) begin
            w_hs++;
            check_eq({tag, " wdata"}, m_wdata, exp_wdata);
            check_eq({tag, " wstrb"}, 32'(m_wstrb), 32'(exp_strb));
         end
         if (m_bvalid && m_bready) begin
            done = 1'b1;
            check_eq({tag, " bp_at_b"}, 32'(lsu_bp_o), 32'd0);
         end else if (!lsu_bp_o) begin
            bp_ok = 1'b0;
         end
         if (m_bready) bk++;
         k++;
      end
      check_eq({tag, " completed"}, 32'(done), 32'd1);
      check_eq({tag, " bp_held"}, 32'(bp_ok), 32'd1);
      check_eq({tag, " aw_count"}, 32'(aw_hs), 32'd1);
      check_eq({tag, " w_count"}, 32'(w_hs), 32'd1);
      @(negedge clk);
      idle_inputs();
      #1;
      check_eq({tag, " trap"}, 32'(trap_o), 32'(resp != 2'b00));
      check_eq({tag, " awvalid_off"}, 32'(m_awvalid | m_wvalid | m_bready), 32'd0);
      if (resp != 2'b00) begin
         check_eq({tag, " cause"}, 32'(trap_cause_o), 32'd7);
         check_eq({tag, " trap_addr"}, trap_addr_o, a);
      end
      @(negedge clk);
      #1 check_eq({tag, " trap_pulse"}, 32'(trap_o), 32'd0);
   endtask

   task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] w,
                           input int ar_dly, input int r_dly, input logic [31:0] rdata,
                           input logic [1:0] resp, input logic [31:0] exp);
      int ar_hs, k, rk;
      bit done, bp_ok;
      ar_hs = 0; k = 0; rk = 0; done = 1'b0; bp_ok = 1'b1;
      @(negedge clk);
      lsu_op_i = 2'd1; lsu_width_i = w; lsu_addr_i = a;
      #1 check_eq({tag, " bp_accept"}, 32'(lsu_bp_o), 32'd1);
      while (!done && k < 60) begin
         @(negedge clk);
         m_arready = (k >= ar_dly);
         m_rvalid  = m_rready && (rk >= r_dly);
         m_rdata   = rdata;
         m_rresp   = resp;
         #1;
         if (m_arvalid && m_arready) begin
            ar_hs++;
            check_eq({tag, " araddr"}, m_araddr, {a[31:2], 2'b00});
         end
         if (m_rvalid && m_rready) begin
            done = 1'b1;
            check_eq({tag, " bp_at_r"}, 32'(lsu_bp_o), 32'd0);
         end else if (!lsu_bp_o) begin
            bp_ok = 1'b0;
         end
         if (m_rready) rk++;
         k++;
      end
      check_eq({tag, " completed"}, 32'(done), 32'd1);
      check_eq({tag, " bp_held"}, 32'(bp_ok), 32'd1);
      check_eq({tag, " ar_count"}, 32'(ar_hs), 32'd1);
      @(negedge clk);
      idle_inputs();
      #1;
      if (resp == 2'b00) begin
         check_eq({tag, " ld_valid"}, 32'(ld_valid_o), 32'd1);
         check_eq({tag, " ld_data"}, ld_data_o, exp);
         check_eq({tag, " no_trap"}, 32'(trap_o), 32'd0);
      end else begin
         check_eq({tag, " ld_valid"}, 32'(ld_valid_o), 32'd0);
         check_eq({tag, " trap"}, 32'(trap_o), 32'd1);
         check_eq({tag, " cause"}, 32'(trap_cause_o), 32'd5);
         check_eq({tag, " trap_addr"}, trap_addr_o, a);
      end
      @(negedge clk);
      #1 check_eq({tag, " pulse"}, 32'(ld_valid_o | trap_o), 32'd0);
   endtask

   task automatic run_mis(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [2:0] w, input logic [3:0] cause);
      @(negedge clk);
      lsu_op_i = op; lsu_width_i = w; lsu_addr_i = a; lsu_wdata_i = 32'h5555_AAAA;
      #1 check_eq({tag, " bp"}, 32'(lsu_bp_o), 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      check_eq({tag, " trap"}, 32'(trap_o), 32'd1);
      check_eq({tag, " cause"}, 32'(trap_cause_o), 32'(cause));
      check_eq({tag, " trap_addr"}, trap_addr_o, a);
      check_eq({tag, " no_bus"}, 32'(m_arvalid | m_awvalid | m_wvalid), 32'd0);
      @(negedge clk);
      #1 check_eq({tag, " trap_pulse"}, 32'(trap_o), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      lsu_width_i = 3'b010; lsu_addr_i = '0; lsu_wdata_i = '0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst outputs", 32'({lsu_bp_o, ld_valid_o, trap_o, m_awvalid, m_wvalid,
                                   m_bready, m_arvalid, m_rready}), 32'd0);
      check_eq("rst ld_data", ld_data_o, 32'd0);
      check_eq("rst trap_info", 32'(trap_cause_o) | trap_addr_o, 32'd0);
      check_eq("rst bus", m_awaddr | m_araddr | m_wdata | 32'(m_wstrb), 32'd0);
      check_eq("rst prot", 32'({m_awprot, m_arprot}), 32'd0);
      rst = 1'b1;

      run_store("SW", 32'h1000, 32'hDEAD_BEEF, 3'b010, 0, 0, 2, 2'b00, 32'hDEAD_BEEF, 4'b1111);
      run_store("SB", 32'h1003, 32'h0000_00A5, 3'b000, 0, 0, 0, 2'b00, 32'hA5A5_A5A5, 4'b1000);
      run_store("SB_awlate", 32'h1003, 32'h0000_00A5, 3'b000, 3, 0, 1, 2'b00,
                32'hA5A5_A5A5, 4'b1000);
      run_store("SH_wlate", 32'h1002, 32'h0000_BEEF, 3'b001, 0, 2, 0, 2'b00,
                32'hBEEF_BEEF, 4'b1100);
      run_store("SW_decerr", 32'h1004, 32'h0BAD_F00D, 3'b010, 1, 1, 1, 2'b11,
                32'h0BAD_F00D, 4'b1111);

      run_load("LB", 32'h2002, 3'b000, 0, 1, 32'h12F0_3456, 2'b00, 32'hFFFF_FFF0);
      run_load("LBU", 32'h2002, 3'b100, 2, 0, 32'h12F0_3456, 2'b00, 32'h0000_00F0);
      run_load("LH", 32'h2002, 3'b001, 1, 2, 32'h12F0_3456, 2'b00, 32'h0000_12F0);
      run_load("LH_neg", 32'h2000, 3'b001, 0, 0, 32'h12F0_8456, 2'b00, 32'hFFFF_8456);
      run_load("LW_slverr", 32'h2000, 3'b010, 0, 1, 32'h1234_5678, 2'b10, 32'h0);

      run_mis("LW_mis", 2'd1, 32'h2001, 3'b010, 4'd4);
      run_mis("SH_mis", 2'd2, 32'h3001, 3'b001, 4'd6);

      // Reset while waiting for R: everything drops at once, then a clean load
      @(negedge clk);
      lsu_op_i = 2'd1; lsu_width_i = 3'b010; lsu_addr_i = 32'h4000;
      @(negedge clk);
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0;
      #1 check_eq("rstmid rready", 32'(m_rready), 32'd1);
      rst = 1'b0;
      lsu_op_i = 2'd0;
      #1;
      check_eq("rstmid flags", 32'({lsu_bp_o, m_rready, m_arvalid, ld_valid_o, trap_o}), 32'd0);
      check_eq("rstmid araddr", m_araddr, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_load("LW_after_rst", 32'h4004, 3'b010, 0, 0, 32'h1122_3344, 2'b00, 32'h1122_3344);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
